// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB state machine driving datapath selects.
// Optional performance counters: define MC_PERF_COUNTERS_EN.
module multicycle_control (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        alu_zero,
  input  logic        alu_lt,
  input  logic        alu_ltu,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        ir_we,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_op,
  output logic        illegal,
  output logic [3:0]  state
`ifdef MC_PERF_COUNTERS_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC     = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_LOAD_WB  = 4'd6,
    S_WB       = 4'd7,
    S_BRANCH   = 4'd8,
    S_LUI_WB   = 4'd9,
    S_ILLEGAL  = 4'd15
  } state_t;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  state_t      cur, nxt;
  logic        run;
  logic        taken;
  logic        mod;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        unused_bits;

  assign opcode      = instr[6:0];
  assign funct3      = instr[14:12];
  assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

  // run holds off the first fetch request until one clock edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur <= S_FETCH;
      run <= 1'b0;
    end else begin
      cur <= nxt;
      run <= 1'b1;
    end
  end

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = alu_zero;
      3'b001:  taken = !alu_zero;
      3'b100:  taken = alu_lt;
      3'b101:  taken = !alu_lt;
      3'b110:  taken = alu_ltu;
      3'b111:  taken = !alu_ltu;
      default: taken = 1'b0;
    endcase
  end

  // SUB/SRA only for R-type; shift-right-immediate alone carries instr[30] for I-arith
  assign mod = (opcode == OP_REG) ? instr[30] : ((funct3 == 3'b101) ? instr[30] : 1'b0);

  always_comb begin
    nxt          = cur;
    pc_we        = 1'b0;
    pc_sel       = 1'b0;
    ir_we        = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    reg_we       = 1'b0;
    wb_sel       = 2'b00;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    alu_op       = 4'b0000;
    case (cur)
      S_FETCH: begin
        mem_req   = run;
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (run && mem_ready) begin
          ir_we = 1'b1;
          pc_we = 1'b1;
          nxt   = S_DECODE;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_REG, OP_IMM:    nxt = S_EXEC;
          OP_LOAD, OP_STORE: nxt = S_MEM_ADDR;
          OP_BRANCH:         nxt = S_BRANCH;
          OP_LUI:            nxt = S_LUI_WB;
          default:           nxt = S_ILLEGAL;
        endcase
      end
      S_EXEC: begin
        alu_src_b = (opcode == OP_IMM) ? 2'b01 : 2'b00;
        alu_op    = {mod, funct3};
        nxt       = S_WB;
      end
      S_MEM_ADDR: begin
        alu_src_b = 2'b01;
        nxt       = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        if (mem_ready) nxt = S_LOAD_WB;
      end
      S_MEM_WR: begin
        mem_req      = 1'b1;
        mem_we       = 1'b1;
        mem_addr_sel = 1'b1;
        if (mem_ready) nxt = S_FETCH;
      end
      S_LOAD_WB: begin
        reg_we = 1'b1;
        wb_sel = 2'b01;
        nxt    = S_FETCH;
      end
      S_WB: begin
        reg_we = 1'b1;
        nxt    = S_FETCH;
      end
      S_LUI_WB: begin
        reg_we = 1'b1;
        wb_sel = 2'b10;
        nxt    = S_FETCH;
      end
      S_BRANCH: begin
        alu_op = 4'b1000;
        if (funct3[2:1] == 2'b01) begin
          nxt = S_ILLEGAL;
        end else begin
          pc_we  = taken;
          pc_sel = taken;
          nxt    = S_FETCH;
        end
      end
      S_ILLEGAL: nxt = S_ILLEGAL;
      default:   nxt = S_ILLEGAL;
    endcase
  end

  // ILLEGAL is left only through reset, so the state itself is the sticky flag
  assign illegal = (cur == S_ILLEGAL);
  assign state   = cur;

`ifdef MC_PERF_COUNTERS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= 32'd0;
      instret_cnt <= 32'd0;
    end else begin
      if (cur != S_ILLEGAL) cycle_cnt <= cycle_cnt + 32'd1;
      if (cur != S_FETCH && nxt == S_FETCH) instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif

endmodule
